// File: rtl/wfid_done_collector.sv
`default_nettype none
// ============================================================================
// Module      : wfid_done_collector
// Description : Gathers single-cycle wavefront-done pulses from NUM_PORTS
//               sources into per-port pending registers, arbitrates them
//               round-robin into a small FIFO and presents the head to a
//               valid/ready consumer. Records the first dropped completion.
// Revision    : 1.0 - initial release
// ============================================================================
module wfid_done_collector #(
    parameter int NUM_PORTS  = 8,
    parameter int WFID_WIDTH = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            wfid_done,
    input  logic [NUM_PORTS*WFID_WIDTH-1:0] wfid,
    output logic [NUM_PORTS-1:0]            port_pending,
    output logic                            muxed_wfid_valid,
    output logic [WFID_WIDTH-1:0]           muxed_wfid,
    input  logic                            muxed_wfid_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow_err,
    output logic [$clog2(NUM_PORTS)-1:0]    err_port
);

    localparam int c_PORT_W = $clog2(NUM_PORTS);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PORT_W-1:0] c_LAST_PORT = c_PORT_W'(NUM_PORTS - 1);
    localparam logic [c_PORT_W:0]   c_NPORTS    = (c_PORT_W+1)'(NUM_PORTS);

    // Per-port capture registers
    logic [NUM_PORTS-1:0]  pending_q, pending_d;
    logic [WFID_WIDTH-1:0] pend_id_q [NUM_PORTS];
    logic [WFID_WIDTH-1:0] pend_id_d [NUM_PORTS];
    logic [c_PORT_W-1:0]   last_grant_q, last_grant_d;

    // Output queue
    logic [WFID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WFID_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;

    // Error capture
    logic                  overflow_q, overflow_d;
    logic [c_PORT_W-1:0]   err_port_q, err_port_d;

    // Combinational control
    logic                  w_pop;
    logic                  w_slot;
    logic                  w_found;
    logic                  w_grant_valid;
    logic [c_PORT_W-1:0]   w_grant_idx;
    logic [c_PORT_W:0]     w_cand;
    logic [NUM_PORTS-1:0]  w_drop;
    logic                  w_granted;

    assign w_pop  = (count_q != '0) && muxed_wfid_ready;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign w_slot = (count_q < c_FULL) || w_pop;

    // Round-robin search: first pending port above last_grant, with wrap
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_cand = {1'b0, last_grant_q} + (c_PORT_W+1)'(i);
            if (w_cand >= c_NPORTS) begin
                w_cand = w_cand - c_NPORTS;
            end
            if (!w_found && pending_q[w_cand[c_PORT_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand[c_PORT_W-1:0];
            end
        end
        w_grant_valid = w_found && w_slot;
    end

    // Pending-register update: capture, clear on grant, detect drops
    always_comb begin
        pending_d    = pending_q;
        pend_id_d    = pend_id_q;
        w_drop       = '0;
        w_granted    = 1'b0;
        last_grant_d = w_grant_valid ? w_grant_idx : last_grant_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_granted = w_grant_valid && (w_grant_idx == c_PORT_W'(p));
            if (w_granted) begin
                pending_d[p] = 1'b0;
            end
            if (wfid_done[p]) begin
                // A port being granted this cycle frees its slot for the new event
                if (!pending_q[p] || w_granted) begin
                    pending_d[p] = 1'b1;
                    pend_id_d[p] = wfid[p*WFID_WIDTH +: WFID_WIDTH];
                end else begin
                    w_drop[p] = 1'b1;
                end
            end
        end
    end

    // Sticky overflow flag; err_port latches lowest dropping port on first drop only
    always_comb begin
        overflow_d = overflow_q | (|w_drop);
        err_port_d = err_port_q;
        if (!overflow_q && (|w_drop)) begin
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (w_drop[p]) begin
                    err_port_d = c_PORT_W'(p);
                end
            end
        end
    end

    // Queue write/read pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_grant_valid) begin
            mem_d[wr_ptr_q] = pend_id_q[w_grant_idx];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_grant_valid, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset gives port 0 first priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            last_grant_q <= c_LAST_PORT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            err_port_q   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pend_id_q[p] <= '0;
            end
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            err_port_q   <= err_port_d;
            pend_id_q    <= pend_id_d;
            mem_q        <= mem_d;
        end
    end

    assign port_pending     = pending_q;
    assign muxed_wfid_valid = (count_q != '0);
    assign muxed_wfid       = mem_q[rd_ptr_q];
    assign fifo_count       = count_q;
    assign overflow_err     = overflow_q;
    assign err_port         = err_port_q;

endmodule
`default_nettype wire

// File: tb/tb_wfid_done_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_wfid_done_collector
// Description : Self-checking bench for wfid_done_collector: reset values,
//               latency, round-robin order, backpressure, drop capture,
//               push-at-full and asynchronous mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wfid_done_collector;

    localparam int NP = 8;
    localparam int W  = 6;
    localparam int D  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     wfid_done;
    logic [NP*W-1:0]   wfid;
    logic [NP-1:0]     port_pending;
    logic              muxed_wfid_valid;
    logic [W-1:0]      muxed_wfid;
    logic              muxed_wfid_ready;
    logic [2:0]        fifo_count;
    logic              overflow_err;
    logic [2:0]        err_port;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb [$];

    typedef struct {
        logic [NP-1:0] done;
        logic          ready;
        logic [2:0]    cnt;
        logic [NP-1:0] pend;
        logic          valid;
    } vec_t;
    vec_t vec [14];

    wfid_done_collector #(.NUM_PORTS(NP), .WFID_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk              (clk),
        .rst              (rst),
        .wfid_done        (wfid_done),
        .wfid             (wfid),
        .port_pending     (port_pending),
        .muxed_wfid_valid (muxed_wfid_valid),
        .muxed_wfid       (muxed_wfid),
        .muxed_wfid_ready (muxed_wfid_ready),
        .fifo_count       (fifo_count),
        .overflow_err     (overflow_err),
        .err_port         (err_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int p, input logic [W-1:0] id);
        wfid[p*W +: W] = id;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wfid_done = '0;
        muxed_wfid_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (fifo_count == 3'd0 && port_pending == '0 && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_done", 32'(ok), 32'd1);
    endtask

    // Scoreboard: every accepted head must match the next expected ID
    always @(negedge clk) begin
        if (!rst && muxed_wfid_valid && muxed_wfid_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", muxed_wfid);
            end else begin
                chk("pop_order", 32'(muxed_wfid), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Backpressure table: all eight ports pulse, queue saturates, then drains
        vec[0]  = '{8'hFF, 1'b0, 3'd0, 8'hFF, 1'b0};
        vec[1]  = '{8'h00, 1'b0, 3'd1, 8'hFE, 1'b1};
        vec[2]  = '{8'h00, 1'b0, 3'd2, 8'hFC, 1'b1};
        vec[3]  = '{8'h00, 1'b0, 3'd3, 8'hF8, 1'b1};
        vec[4]  = '{8'h00, 1'b0, 3'd4, 8'hF0, 1'b1};
        vec[5]  = '{8'h00, 1'b0, 3'd4, 8'hF0, 1'b1};
        vec[6]  = '{8'h00, 1'b1, 3'd4, 8'hE0, 1'b1};
        vec[7]  = '{8'h00, 1'b1, 3'd4, 8'hC0, 1'b1};
        vec[8]  = '{8'h00, 1'b1, 3'd4, 8'h80, 1'b1};
        vec[9]  = '{8'h00, 1'b1, 3'd4, 8'h00, 1'b1};
        vec[10] = '{8'h00, 1'b1, 3'd3, 8'h00, 1'b1};
        vec[11] = '{8'h00, 1'b1, 3'd2, 8'h00, 1'b1};
        vec[12] = '{8'h00, 1'b1, 3'd1, 8'h00, 1'b1};
        vec[13] = '{8'h00, 1'b1, 3'd0, 8'h00, 1'b0};

        rst = 1'b1;
        wfid_done = '0;
        wfid = '0;
        muxed_wfid_ready = 1'b0;
        tick();
        tick();
        chk("rst_count",    32'(fifo_count),       32'd0);
        chk("rst_valid",    32'(muxed_wfid_valid), 32'd0);
        chk("rst_pending",  32'(port_pending),     32'd0);
        chk("rst_wfid",     32'(muxed_wfid),       32'd0);
        chk("rst_overflow", 32'(overflow_err),     32'd0);
        chk("rst_err_port", 32'(err_port),         32'd0);
        rst = 1'b0;

        // Single completion: one-edge capture, granted the next edge
        set_id(3, 6'h15);
        wfid_done = 8'h08;
        muxed_wfid_ready = 1'b1;
        sb.push_back(6'h15);
        tick();
        wfid_done = '0;
        chk("single_pending", 32'(port_pending),     32'h08);
        chk("single_valid0",  32'(muxed_wfid_valid), 32'd0);
        tick();
        chk("single_valid1",  32'(muxed_wfid_valid), 32'd1);
        chk("single_wfid",    32'(muxed_wfid),       32'h15);
        chk("single_count1",  32'(fifo_count),       32'd1);
        chk("single_pend0",   32'(port_pending),     32'd0);
        tick();
        chk("single_count0",  32'(fifo_count),       32'd0);

        // Round-robin: ports 0,2,5 together, port 0 re-pulses while being granted
        do_reset();
        muxed_wfid_ready = 1'b1;
        set_id(0, 6'h01);
        set_id(2, 6'h02);
        set_id(5, 6'h05);
        wfid_done = 8'h25;
        sb.push_back(6'h01);
        sb.push_back(6'h02);
        sb.push_back(6'h05);
        sb.push_back(6'h20);
        tick();
        set_id(0, 6'h20);
        wfid_done = 8'h01;
        tick();
        wfid_done = '0;
        chk("rr_regrant_pending", 32'(port_pending), 32'h25);
        wait_drain(20);

        // Backpressure table
        do_reset();
        for (int p = 0; p < NP; p++) begin
            set_id(p, W'(8'h10 + p));
            sb.push_back(W'(8'h10 + p));
        end
        for (int i = 0; i < 14; i++) begin
            wfid_done = vec[i].done;
            muxed_wfid_ready = vec[i].ready;
            tick();
            chk($sformatf("tbl%0d_count", i),   32'(fifo_count),       32'(vec[i].cnt));
            chk($sformatf("tbl%0d_pending", i), 32'(port_pending),     32'(vec[i].pend));
            chk($sformatf("tbl%0d_valid", i),   32'(muxed_wfid_valid), 32'(vec[i].valid));
            chk($sformatf("tbl%0d_ovf", i),     32'(overflow_err),     32'd0);
        end
        chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

        // Drop: port 6 pulses again while still pending behind a full queue
        do_reset();
        for (int p = 0; p < 4; p++) set_id(p, W'(8'h30 + p));
        set_id(6, 6'h26);
        wfid_done = 8'h4F;
        tick();
        wfid_done = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("drop_full_count", 32'(fifo_count),   32'd4);
        chk("drop_no_ovf",     32'(overflow_err), 32'd0);
        set_id(6, 6'h3F);
        wfid_done = 8'h40;
        tick();
        wfid_done = '0;
        chk("drop_ovf",      32'(overflow_err), 32'd1);
        chk("drop_err_port", 32'(err_port),     32'd6);
        chk("drop_pending",  32'(port_pending), 32'h40);
        set_id(7, 6'h27);
        wfid_done = 8'h80;
        tick();
        set_id(7, 6'h2A);
        tick();
        wfid_done = '0;
        chk("drop_err_keep", 32'(err_port),     32'd6);
        chk("drop_pending2", 32'(port_pending), 32'hC0);
        for (int p = 0; p < 4; p++) sb.push_back(W'(8'h30 + p));
        sb.push_back(6'h26);
        sb.push_back(6'h27);
        muxed_wfid_ready = 1'b1;
        wait_drain(30);
        chk("drop_ovf_sticky", 32'(overflow_err), 32'd1);

        // Push at full with simultaneous pop
        do_reset();
        for (int p = 0; p < 4; p++) set_id(p, W'(8'h40 + p));
        set_id(5, 6'h05);
        wfid_done = 8'h2F;
        tick();
        wfid_done = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("pf_count_full", 32'(fifo_count),   32'd4);
        chk("pf_pending",    32'(port_pending), 32'h20);
        for (int p = 0; p < 4; p++) sb.push_back(W'(8'h40 + p));
        sb.push_back(6'h05);
        muxed_wfid_ready = 1'b1;
        tick();
        chk("pf_count_hold", 32'(fifo_count),   32'd4);
        chk("pf_pending0",   32'(port_pending), 32'd0);
        wait_drain(20);

        // Asynchronous reset mid-run with queued and pending entries
        do_reset();
        for (int p = 0; p < NP; p++) set_id(p, W'(8'h30 + p));
        wfid_done = 8'h57;
        tick();
        wfid_done = '0;
        for (int i = 0; i < 3; i++) tick();
        chk("mr_count3",  32'(fifo_count),   32'd3);
        chk("mr_pending", 32'(port_pending), 32'h50);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_count0",   32'(fifo_count),       32'd0);
        chk("mr_valid0",   32'(muxed_wfid_valid), 32'd0);
        chk("mr_pend0",    32'(port_pending),     32'd0);
        chk("mr_wfid0",    32'(muxed_wfid),       32'd0);
        set_id(1, 6'h11);
        wfid_done = 8'h02;
        tick();
        rst = 1'b0;
        wfid_done = '0;
        chk("mr_release_ignored", 32'(port_pending), 32'd0);
        set_id(2, 6'h22);
        set_id(5, 6'h25);
        wfid_done = 8'h24;
        muxed_wfid_ready = 1'b1;
        sb.push_back(6'h22);
        sb.push_back(6'h25);
        tick();
        wfid_done = '0;
        wait_drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wfid_done_collector.md
WFID_DONE_COLLECTOR -- requirements
Module: wfid_done_collector

Interface
REQ-001 Parameter NUM_PORTS, default 8, number of wavefront-done source ports (2..16).
REQ-002 Parameter WFID_WIDTH, default 6, wavefront ID width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4, output queue depth (power of 2, >=2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wfid_done  input  NUM_PORTS  per-port single-cycle completion pulse.
REQ-007 wfid  input  NUM_PORTS*WFID_WIDTH  per-port ID; port p occupies bits [p*WFID_WIDTH +: WFID_WIDTH]; sampled only when its done bit is high.
REQ-008 port_pending  output  NUM_PORTS  bit p high while port p holds a captured, not-yet-queued completion.
REQ-009 muxed_wfid_valid  output  1  queue head valid.
REQ-010 muxed_wfid  output  WFID_WIDTH  queue head ID.
REQ-011 muxed_wfid_ready  input  1  consumer accepts head when high with valid.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued.
REQ-013 overflow_err  output  1  sticky flag: a completion was dropped.
REQ-014 err_port  output  $clog2(NUM_PORTS)  index of port causing the first drop.

Function
REQ-015 Each port has one pending register (flag + WFID_WIDTH ID); port_pending reflects the flags directly.
REQ-016 On an edge where wfid_done[p]=1 and (pending[p]=0 or port p is granted that cycle), pending[p] is set and the ID of port p is captured.
REQ-017 On an edge where wfid_done[p]=1, pending[p]=1 and port p is not granted, the new event is dropped, the stored ID is unchanged, and overflow_err is set.
REQ-018 err_port is loaded only on the edge that first sets overflow_err; if several ports drop on that edge, the lowest index is recorded; later drops do not change it.
REQ-019 A push slot exists in a cycle when fifo_count < FIFO_DEPTH, or when fifo_count = FIFO_DEPTH and a pop occurs in the same cycle.
REQ-020 When a push slot exists and any pending flag is set, exactly one port is granted, chosen round-robin: the first pending port searching upward (with wrap) from last_grant+1.
REQ-021 The granted port's ID is written at the tail, its pending flag is cleared (unless re-set per REQ-016), and last_grant is updated to that index.
REQ-022 With no push slot or no pending port, no grant occurs and last_grant holds.
REQ-023 Latency: a done pulse sampled at edge t, with the queue empty and no contention, is granted at edge t+1; muxed_wfid_valid is high and muxed_wfid correct after edge t+1.
REQ-024 muxed_wfid_valid = (fifo_count != 0); muxed_wfid is driven from registered queue storage at the read pointer; when the queue is empty it holds the last value and is don't-care.
REQ-025 Pop occurs when muxed_wfid_valid and muxed_wfid_ready are both high; ready while empty has no effect.
REQ-026 Simultaneous push and pop leaves fifo_count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-027 Entries leave the queue in grant order; no entry is duplicated or lost except as in REQ-017.
REQ-028 overflow_err clears only on reset.

Reset
REQ-029 While rst is high: all pending flags, fifo_count, pointers, overflow_err, err_port, muxed_wfid_valid and muxed_wfid are 0, and last_grant = NUM_PORTS-1 so port 0 has first priority.
REQ-030 Reset asserted mid-operation discards all pending and queued entries immediately; done pulses coincident with the rst release edge are ignored.

Verification
REQ-031 Single: rst released, wfid_done[3]=1 with ID 6'h15 for one cycle, ready=1 -> valid high after the next edge with muxed_wfid=6'h15, popped the cycle after, fifo_count returns to 0.
REQ-032 Round-robin: ports 0,2,5 pulse on the same edge with IDs 1,2,5, ready=1 -> outputs appear in order 1,2,5 on consecutive cycles; a port-0 re-pulse then comes out after port 5.
REQ-033 Full/backpressure: ready=0, eight ports pulse once each (NUM_PORTS=8, FIFO_DEPTH=4) -> fifo_count saturates at 4, port_pending=4 bits set, no overflow; ready=1 drains all 8 in round-robin order.
REQ-034 Drop: ready=0, queue full, port 6 pulses twice -> overflow_err=1, err_port=6, first ID retained and delivered after ready=1.
REQ-035 Push at full with pop: queue full, ready=1, one pending port -> fifo_count stays 4 and the pending entry is queued that edge.
REQ-036 Mid-run reset: queue holding 3 entries, 2 pending, rst pulsed asynchronously -> all outputs 0 immediately; post-reset first grant goes to the lowest pending port.
